// File: rtl/chacha_pkg.sv
// Shared constants, state encoding and rotate helper for the ChaCha stream engine.
package chacha_pkg;

  localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  localparam int unsigned KEY_BASE   = 0;
  localparam int unsigned NONCE_BASE = 32;
  localparam int unsigned CTR_BASE   = 44;

  localparam int unsigned ROT_A = 16;
  localparam int unsigned ROT_B = 12;
  localparam int unsigned ROT_C = 8;
  localparam int unsigned ROT_D = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_ROUND  = 3'd2,
    ST_FINAL  = 3'd3,
    ST_STREAM = 3'd4
  } state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  input  logic [31:0] d_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out
);

  logic [31:0] a1, b1, c1, d1;

  always_comb begin
    a1    = a_in + b_in;
    d1    = rotl32(d_in ^ a1, ROT_A);
    c1    = c_in + d1;
    b1    = rotl32(b_in ^ c1, ROT_B);
    a_out = a1 + b1;
    d_out = rotl32(d1 ^ a_out, ROT_C);
    c_out = c1 + d_out;
    b_out = rotl32(b1 ^ c_out, ROT_D);
  end

endmodule

// File: rtl/chacha_stream_core.sv
// ChaCha block engine with config load, one round per cycle and keystream XOR
// onto a valid/ready beat stream, advancing the block counter per 64-byte block.
module chacha_stream_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS     = 20,
  parameter int BEAT_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [5:0]              cfg_addr,
  input  logic [7:0]              cfg_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    in_valid,
  input  logic [8*BEAT_BYTES-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [8*BEAT_BYTES-1:0] out_data,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    ctr_wrap
);

  localparam int BEATS = 64 / BEAT_BYTES;
  localparam int BW    = $clog2(BEATS);
  localparam int DW    = 8 * BEAT_BYTES;
  localparam logic [4:0]    LAST_RND  = 5'(ROUNDS - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_stream_core: ROUNDS must be 8, 12 or 20");
  end
  if (!(BEAT_BYTES == 1 || BEAT_BYTES == 2 || BEAT_BYTES == 4 || BEAT_BYTES == 8)) begin : g_bad_beat
    $error("chacha_stream_core: BEAT_BYTES must be 1, 2, 4 or 8");
  end

  state_t        state;
  logic [31:0]   key   [8];
  logic [31:0]   nonce [3];
  logic [31:0]   ctr;
  logic [31:0]   work  [16];
  logic [31:0]   orig  [16];
  logic [31:0]   init_m    [16];
  logic [31:0]   next_work [16];
  logic [511:0]  ks, ks_next;
  logic [DW-1:0] ks_beats [BEATS];
  logic [BW-1:0] beat;
  logic [4:0]    rnd;
  logic [31:0]   qi [4][4];
  logic [31:0]   qo [4][4];
  logic          in_fire;

  for (genvar i = 0; i < 4; i++) begin : g_sigma
    assign init_m[i] = SIGMA[i];
  end
  for (genvar i = 0; i < 8; i++) begin : g_key
    assign init_m[4+i] = key[i];
  end
  assign init_m[12] = ctr;
  for (genvar i = 0; i < 3; i++) begin : g_nonce
    assign init_m[13+i] = nonce[i];
  end

  // Lane g reads row r from column g (column round) or (g+r)%4 (diagonal round);
  // write-back inverts that mapping so each matrix element has a single source.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign qi[g][r] = rnd[0] ? work[4*r + (g+r)%4] : work[4*r + g];
    end
    chacha_qr u_qr (
      .a_in  (qi[g][0]),
      .b_in  (qi[g][1]),
      .c_in  (qi[g][2]),
      .d_in  (qi[g][3]),
      .a_out (qo[g][0]),
      .b_out (qo[g][1]),
      .c_out (qo[g][2]),
      .d_out (qo[g][3])
    );
  end

  for (genvar e = 0; e < 16; e++) begin : g_elem
    assign next_work[e]        = rnd[0] ? qo[(e%4 + 4 - e/4) % 4][e/4] : qo[e%4][e/4];
    assign ks_next[32*e +: 32] = work[e] + orig[e];
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign ks_beats[b] = ks[DW*b +: DW];
  end

  assign busy     = (state != ST_IDLE);
  assign in_ready = (state == ST_STREAM) && !stop && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      key       <= '{default: '0};
      nonce     <= '{default: '0};
      ctr       <= '0;
      work      <= '{default: '0};
      orig      <= '{default: '0};
      ks        <= '0;
      beat      <= '0;
      rnd       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ctr_wrap  <= 1'b0;
    end else begin
      ctr_wrap <= 1'b0;
      if (state == ST_IDLE && cfg_we) begin
        if (cfg_addr < 6'(NONCE_BASE)) begin
          key[cfg_addr[4:2]][{cfg_addr[1:0], 3'b000} +: 8] <= cfg_data;
        end else if (cfg_addr < 6'(CTR_BASE)) begin
          nonce[cfg_addr[3:2]][{cfg_addr[1:0], 3'b000} +: 8] <= cfg_data;
        end else if (cfg_addr < 6'(CTR_BASE + 4)) begin
          ctr[{cfg_addr[1:0], 3'b000} +: 8] <= cfg_data;
        end
      end
      if (stop) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
      end else begin
        if (in_fire) begin
          out_data  <= in_data ^ ks_beats[beat];
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        case (state)
          ST_IDLE: if (start) state <= ST_INIT;
          ST_INIT: begin
            work  <= init_m;
            orig  <= init_m;
            rnd   <= '0;
            state <= ST_ROUND;
          end
          ST_ROUND: begin
            work <= next_work;
            rnd  <= rnd + 5'd1;
            if (rnd == LAST_RND) state <= ST_FINAL;
          end
          ST_FINAL: begin
            ks    <= ks_next;
            beat  <= '0;
            state <= ST_STREAM;
          end
          ST_STREAM: if (in_fire) begin
            beat <= beat + BW'(1);
            if (beat == LAST_BEAT) begin
              ctr      <= ctr + 32'd1;
              ctr_wrap <= (ctr == '1);
              state    <= ST_INIT;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_stream_core.sv
// Directed/randomised bench for chacha_stream_core against an RFC 8439 block-function model.
module tb_chacha_stream_core;

  localparam int RA = 20;
  localparam int RB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_we, start, stop, in_valid, in_ready, out_valid, out_ready, busy, ctr_wrap;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_data, in_data, out_data;
  logic        start_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b, ctr_wrap_b;
  logic [31:0] in_data_b, out_data_b;

  chacha_stream_core #(.ROUNDS(RA), .BEAT_BYTES(1)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
    .ctr_wrap(ctr_wrap)
  );

  chacha_stream_core #(.ROUNDS(RB), .BEAT_BYTES(4)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start_b), .stop(stop), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_ready(out_ready_b), .busy(busy_b), .ctr_wrap(ctr_wrap_b)
  );

  int checks = 0;
  int errors = 0;
  int wrap_cnt;
  logic [7:0]  key_b [32];
  logic [7:0]  non_b [12];
  logic [7:0]  pt    [256];
  logic [7:0]  got   [256];
  logic [7:0]  exp_q [256];
  logic [31:0] mx    [16];
  logic [7:0]  kat1  [16] = '{8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15,
                              8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4};
  logic [7:0]  kat2  [8]  = '{8'h6e, 8'h2e, 8'h35, 8'h9a, 8'h25, 8'h68, 8'hf9, 8'h80};
  string msg = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void qr_m(input int a, input int b, input int c, input int d);
    mx[a] = mx[a] + mx[b]; mx[d] = rl(mx[d] ^ mx[a], 16);
    mx[c] = mx[c] + mx[d]; mx[b] = rl(mx[b] ^ mx[c], 12);
    mx[a] = mx[a] + mx[b]; mx[d] = rl(mx[d] ^ mx[a], 8);
    mx[c] = mx[c] + mx[d]; mx[b] = rl(mx[b] ^ mx[c], 7);
  endfunction

  // RFC 8439 block function: serialised keystream for counter c lands in exp_q[off +: 64].
  function automatic void model_block(input logic [31:0] c, input int rounds, input int off);
    logic [31:0] o [16];
    logic [31:0] w;
    mx[0] = 32'h61707865; mx[1] = 32'h3320646e; mx[2] = 32'h79622d32; mx[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      mx[4+i] = {key_b[4*i+3], key_b[4*i+2], key_b[4*i+1], key_b[4*i]};
    mx[12] = c;
    for (int i = 0; i < 3; i++)
      mx[13+i] = {non_b[4*i+3], non_b[4*i+2], non_b[4*i+1], non_b[4*i]};
    o = mx;
    for (int r = 0; r < rounds / 2; r++) begin
      qr_m(0, 4, 8, 12); qr_m(1, 5, 9, 13); qr_m(2, 6, 10, 14); qr_m(3, 7, 11, 15);
      qr_m(0, 5, 10, 15); qr_m(1, 6, 11, 12); qr_m(2, 7, 8, 13); qr_m(3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) begin
      w = mx[i] + o[i];
      for (int j = 0; j < 4; j++) exp_q[off + 4*i + j] = w[8*j +: 8] ^ pt[off + 4*i + j];
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string tag, input int n);
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 6'(a); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] c);
    for (int i = 0; i < 32; i++) wr(i, key_b[i]);
    for (int i = 0; i < 12; i++) wr(32 + i, non_b[i]);
    for (int j = 0; j < 4; j++) wr(44 + j, c[8*j +: 8]);
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < 32; i++) key_b[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) non_b[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) pt[i] = 8'($urandom);
  endtask

  task automatic start_a(input int lat);
    int n = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("latency_a", 64'(n), 64'(lat));
  endtask

  task automatic start_bb(input int lat);
    int n = 0;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    while (!in_ready_b && n < 200) begin @(posedge clk); #1; n++; end
    chk("latency_b", 64'(n), 64'(lat));
  endtask

  task automatic stop_a();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_busy", 64'(busy), 64'(0));
    chk("stop_out_valid", 64'(out_valid), 64'(0));
  endtask

  task automatic stream_a(input int n, input bit bp);
    int sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < n && cyc < 20000) begin
      @(negedge clk);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < n) && (!bp || $urandom_range(0, 3) != 0);
      in_data   = pt[sent];
      #1;
      if (ctr_wrap) wrap_cnt++;
      if (out_valid && out_ready) begin got[rcvd] = out_data; rcvd++; end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("stream_a_count", 64'(rcvd), 64'(n));
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic stream_b(input int nb);
    int sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < nb && cyc < 20000) begin
      @(negedge clk);
      out_ready_b = 1'b1;
      in_valid_b  = (sent < nb);
      in_data_b   = {pt[4*sent+3], pt[4*sent+2], pt[4*sent+1], pt[4*sent]};
      #1;
      if (out_valid_b && out_ready_b) begin
        for (int j = 0; j < 4; j++) got[4*rcvd+j] = out_data_b[8*j +: 8];
        rcvd++;
      end
      if (in_valid_b && in_ready_b) sent++;
      cyc++;
    end
    chk("stream_b_count", 64'(rcvd), 64'(nb));
    @(negedge clk); in_valid_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ctr_wrap", 64'(ctr_wrap), 64'(0));
    rst = 1'b0;

    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 64'(busy), 64'(0));

    // RFC 8439 2.3.2 keystream via zero plaintext
    for (int i = 0; i < 32; i++) key_b[i] = 8'(i);
    for (int i = 0; i < 12; i++) non_b[i] = 8'h00;
    non_b[3] = 8'h09; non_b[7] = 8'h4a;
    for (int i = 0; i < 256; i++) pt[i] = 8'h00;
    load_cfg(32'd1);
    start_a(RA + 2);
    stream_a(64, 1'b0);
    for (int i = 0; i < 16; i++) chk($sformatf("rfc232_kat[%0d]", i), 64'(got[i]), 64'(kat1[i]));
    model_block(32'd1, RA, 0);
    cmp("rfc232", 64);
    stop_a();

    // RFC 8439 2.4.2 encryption, two blocks
    non_b[3] = 8'h00;
    for (int i = 0; i < msg.len(); i++) pt[i] = msg[i];
    load_cfg(32'd1);
    start_a(RA + 2);
    stream_a(msg.len(), 1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("rfc242_kat[%0d]", i), 64'(got[i]), 64'(kat2[i]));
    model_block(32'd1, RA, 0);
    model_block(32'd2, RA, 64);
    cmp("rfc242", msg.len());
    stop_a();

    // Same message with random source gaps and sink back-pressure
    load_cfg(32'd1);
    start_a(RA + 2);
    stream_a(msg.len(), 1'b1);
    cmp("rfc242_bp", msg.len());
    stop_a();

    // Counter wrap across two blocks
    rand_cfg();
    load_cfg(32'hFFFF_FFFF);
    wrap_cnt = 0;
    start_a(RA + 2);
    stream_a(128, 1'b0);
    chk("wrap_count", 64'(wrap_cnt), 64'(1));
    model_block(32'hFFFF_FFFF, RA, 0);
    model_block(32'h0, RA, 64);
    cmp("wrap", 128);
    stop_a();

    // Config writes while busy are ignored; stop mid-block keeps the advanced counter
    rand_cfg();
    load_cfg(32'd5);
    start_a(RA + 2);
    wr(0, ~key_b[0]);
    wr(44, 8'h55);
    stream_a(74, 1'b0);
    model_block(32'd5, RA, 0);
    model_block(32'd6, RA, 64);
    cmp("busy_cfg", 74);
    stop_a();
    start_a(RA + 2);
    stream_a(64, 1'b0);
    model_block(32'd6, RA, 0);
    cmp("resume_ctr", 64);
    stop_a();

    // Reset in the middle of the round phase clears config too
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_round_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 32; i++) key_b[i] = 8'h00;
    for (int i = 0; i < 12; i++) non_b[i] = 8'h00;
    start_a(RA + 2);
    stream_a(16, 1'b0);
    model_block(32'd0, RA, 0);
    cmp("post_rst_zero_cfg", 16);
    stop_a();

    // Reduced-round, 4-byte-beat instance over two blocks
    rand_cfg();
    begin
      logic [31:0] c0;
      c0 = $urandom;
      load_cfg(c0);
      start_bb(RB + 2);
      stream_b(32);
      model_block(c0, RB, 0);
      model_block(c0 + 32'd1, RB, 64);
      cmp("r12_beat4", 128);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
